// File: rtl/decode_stage_pkg.sv
// Shared decode constants: RV32 opcodes that matter to decode and hazard
// detection, the immediate-select encodings (also consumed by imm_gen), the
// decode FSM state type and small opcode classification helpers.
package decode_stage_pkg;

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [1:0] IMM_NONE = 2'd0;
  localparam logic [1:0] IMM_I    = 2'd1;
  localparam logic [1:0] IMM_S    = 2'd2;
  localparam logic [1:0] IMM_B    = 2'd3;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_VALID = 1'b1
  } state_e;

  // Immediate format selected by an opcode.
  function automatic logic [1:0] imm_sel_of(input logic [6:0] opc);
    case (opc)
      OPC_OP_IMM, OPC_LOAD, OPC_JALR: imm_sel_of = IMM_I;
      OPC_STORE:                      imm_sel_of = IMM_S;
      OPC_BRANCH:                     imm_sel_of = IMM_B;
      default:                        imm_sel_of = IMM_NONE;
    endcase
  endfunction

  // Opcodes whose rs1 field names a real source register.
  function automatic logic uses_rs1_of(input logic [6:0] opc);
    case (opc)
      OPC_OP_IMM, OPC_LOAD, OPC_JALR,
      OPC_STORE, OPC_BRANCH, OPC_OP: uses_rs1_of = 1'b1;
      default:                       uses_rs1_of = 1'b0;
    endcase
  endfunction

  // Opcodes whose rs2 field names a real source register.
  function automatic logic uses_rs2_of(input logic [6:0] opc);
    case (opc)
      OPC_STORE, OPC_BRANCH, OPC_OP: uses_rs2_of = 1'b1;
      default:                       uses_rs2_of = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Fetch-side and execute-side handshake bundle of the decode stage.
// master: the surrounding pipeline (drives fetch offer, flush, id_ready).
// slave : the decode stage (drives if_ready and all decoded outputs).
interface decode_stage_if;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_inst;
  logic [31:0] if_pc;
  logic        flush;
  logic        id_ready;
  logic        id_valid;
  logic [31:0] id_inst;
  logic [31:0] id_pc;
  logic [24:0] imm_inst;
  logic [1:0]  imm_sel;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [4:0]  rd;

  modport master (
    output if_valid, if_inst, if_pc, flush, id_ready,
    input  if_ready, id_valid, id_inst, id_pc, imm_inst, imm_sel, rs1, rs2, rd
  );

  modport slave (
    input  if_valid, if_inst, if_pc, flush, id_ready,
    output if_ready, id_valid, id_inst, id_pc, imm_inst, imm_sel, rs1, rs2, rd
  );
endinterface

// File: rtl/decode_stage_load_use_detect.sv
// Load-use hazard compare: flags when the held instruction reads the
// destination of the load that most recently left the stage.
// Ports: valid_i (stage holds an instruction), last_ld_i / last_rd_i (last
// transferred-out instruction was a load / its rd), opcode_i, rs1_i, rs2_i
// (fields of the held instruction), hazard_o.
module load_use_detect
  import decode_stage_pkg::*;
(
  input  logic       valid_i,
  input  logic       last_ld_i,
  input  logic [4:0] last_rd_i,
  input  logic [6:0] opcode_i,
  input  logic [4:0] rs1_i,
  input  logic [4:0] rs2_i,
  output logic       hazard_o
);
  logic src_hit;

  // Dependency compare; x0 is never a real dependency.
  always_comb begin
    src_hit  = (uses_rs1_of(opcode_i) && (rs1_i == last_rd_i)) ||
               (uses_rs2_of(opcode_i) && (rs2_i == last_rd_i));
    hazard_o = valid_i && last_ld_i && (last_rd_i != 5'd0) && src_hit;
  end
endmodule

// File: rtl/decode_stage.sv
// Single-entry decode stage with load-use bubble insertion.
// Ports: clk, rst_n (async active-low), bus (decode_stage_if.slave):
//   fetch side if_valid/if_ready/if_inst/if_pc, flush from branch resolution,
//   execute side id_ready/id_valid/id_inst/id_pc, immediate generator feed
//   imm_inst/imm_sel, register indices rs1/rs2/rd.
module decode_stage
  import decode_stage_pkg::*;
#(
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input logic           clk,
  input logic           rst_n,
  decode_stage_if.slave bus
);
  state_e      state_q, state_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] pc_q, pc_d;
  logic        last_ld_q, last_ld_d;
  logic [4:0]  last_rd_q, last_rd_d;

  logic        is_valid;
  logic        hazard;
  logic        if_ready;
  logic        xfer_in;
  logic        xfer_out;
  logic [31:0] id_inst;
  logic [1:0]  imm_sel;

  assign is_valid = (state_q == ST_VALID);

  load_use_detect u_load_use_detect (
    .valid_i   (is_valid),
    .last_ld_i (last_ld_q),
    .last_rd_i (last_rd_q),
    .opcode_i  (inst_q[6:0]),
    .rs1_i     (inst_q[19:15]),
    .rs2_i     (inst_q[24:20]),
    .hazard_o  (hazard)
  );

  // Presented instruction: a bubble replaces the held one during a hazard.
  // imm_sel is forced to none when empty or bubbling (the NOP itself is an
  // OP-IMM and would otherwise select I).
  always_comb begin
    id_inst = inst_q;
    imm_sel = IMM_NONE;
    if (hazard) begin
      id_inst = NOP_INST;
      imm_sel = IMM_NONE;
    end else if (is_valid) begin
      imm_sel = imm_sel_of(inst_q[6:0]);
    end else begin
      imm_sel = IMM_NONE;
    end
  end

  // Accept from fetch only when the slot is free or drains this cycle.
  always_comb begin
    if (!rst_n) begin
      if_ready = 1'b0;
    end else if (bus.flush) begin
      if_ready = 1'b0;
    end else if (state_q == ST_EMPTY) begin
      if_ready = 1'b1;
    end else if (bus.id_ready && !hazard) begin
      if_ready = 1'b1;
    end else begin
      if_ready = 1'b0;
    end
  end

  assign xfer_in  = bus.if_valid && if_ready;
  assign xfer_out = is_valid && bus.id_ready;

  // Next-state logic: flush dominates; a transferred-out bubble keeps the
  // held instruction so it is presented again next cycle.
  always_comb begin
    state_d   = state_q;
    inst_d    = inst_q;
    pc_d      = pc_q;
    last_ld_d = last_ld_q;
    last_rd_d = last_rd_q;
    if (xfer_out) begin
      last_ld_d = (id_inst[6:0] == OPC_LOAD);
      last_rd_d = id_inst[11:7];
    end else begin
      last_ld_d = last_ld_q;
      last_rd_d = last_rd_q;
    end
    if (bus.flush) begin
      state_d   = ST_EMPTY;
      last_ld_d = 1'b0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (xfer_in) begin
            state_d = ST_VALID;
            inst_d  = bus.if_inst;
            pc_d    = bus.if_pc;
          end else begin
            state_d = ST_EMPTY;
          end
        end
        ST_VALID: begin
          if (xfer_in) begin
            state_d = ST_VALID;
            inst_d  = bus.if_inst;
            pc_d    = bus.if_pc;
          end else if (xfer_out && !hazard) begin
            state_d = ST_EMPTY;
          end else begin
            state_d = ST_VALID;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  // State and pipeline register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_EMPTY;
      inst_q    <= NOP_INST;
      pc_q      <= 32'd0;
      last_ld_q <= 1'b0;
      last_rd_q <= 5'd0;
    end else begin
      state_q   <= state_d;
      inst_q    <= inst_d;
      pc_q      <= pc_d;
      last_ld_q <= last_ld_d;
      last_rd_q <= last_rd_d;
    end
  end

  assign bus.if_ready = if_ready;
  assign bus.id_valid = is_valid;
  assign bus.id_inst  = id_inst;
  assign bus.id_pc    = pc_q;
  assign bus.imm_inst = id_inst[31:7];
  assign bus.imm_sel  = imm_sel;
  assign bus.rs1      = id_inst[19:15];
  assign bus.rs2      = id_inst[24:20];
  assign bus.rd       = id_inst[11:7];
endmodule

// File: tb/tb_decode_stage.sv
module tb_decode_stage;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } entry_t;

  logic clk = 1'b0;
  logic rst_n;
  decode_stage_if bus();

  decode_stage #(.NOP_INST(NOP)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Reference model: the stage holds at most one instruction; a load leaving
  // the stage makes the next reader of its rd wait behind one NOP.
  entry_t      slot[$];
  bit          m_ld;
  logic [4:0]  m_rd;
  bit          m_ready;
  logic        c_v, c_fl, c_rdy;
  logic [31:0] c_inst, c_pc;

  function automatic bit reads_reg(input logic [31:0] i, input logic [4:0] r);
    int op;
    bit r1, r2;
    op = int'(i[6:0]);
    r1 = op inside {'h13, 'h03, 'h67, 'h23, 'h63, 'h33};
    r2 = op inside {'h23, 'h63, 'h33};
    return (r1 && i[19:15] == r) || (r2 && i[24:20] == r);
  endfunction

  function automatic bit bubble_now();
    if (slot.size() == 0) return 1'b0;
    return m_ld && (m_rd != 5'd0) && reads_reg(slot[0].inst, m_rd);
  endfunction

  function automatic logic [1:0] imm_kind(input logic [31:0] i);
    int op;
    op = int'(i[6:0]);
    if (op == 'h13 || op == 'h03 || op == 'h67) return 2'd1;
    if (op == 'h23) return 2'd2;
    if (op == 'h63) return 2'd3;
    return 2'd0;
  endfunction

  function automatic logic [31:0] shown_inst();
    if (slot.size() == 0) return NOP;
    return bubble_now() ? NOP : slot[0].inst;
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [6:0]  ops [8] = '{7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h33, 7'h37, 7'h6f};
    logic [31:0] i;
    i        = $urandom;
    i[6:0]   = ops[$urandom_range(0, 7)];
    i[11:7]  = 5'($urandom_range(0, 3));
    i[19:15] = 5'($urandom_range(0, 3));
    i[24:20] = 5'($urandom_range(0, 3));
    return i;
  endfunction

  task automatic model_reset();
    slot.delete();
    m_ld = 1'b0;
    m_rd = 5'd0;
  endtask

  // Drive one cycle of inputs and compare what the stage presents.
  task automatic step(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                      input logic fl, input logic rdy);
    logic [31:0] si;
    bit          full, bub;
    @(negedge clk);
    bus.if_valid = v;  bus.if_inst = inst; bus.if_pc = pc;
    bus.flush    = fl; bus.id_ready = rdy;
    c_v = v; c_inst = inst; c_pc = pc; c_fl = fl; c_rdy = rdy;
    #1;
    full    = slot.size() != 0;
    bub     = bubble_now();
    si      = shown_inst();
    m_ready = !fl && (!full || (rdy && !bub));
    check_eq("if_ready", 32'(bus.if_ready), 32'(m_ready));
    check_eq("id_valid", 32'(bus.id_valid), 32'(full));
    check_eq("imm_sel", 32'(bus.imm_sel), (full && !bub) ? 32'(imm_kind(si)) : 32'd0);
    if (full) begin
      check_eq("id_inst", bus.id_inst, si);
      check_eq("id_pc", bus.id_pc, slot[0].pc);
      check_eq("imm_inst", 32'(bus.imm_inst), 32'(si[31:7]));
      check_eq("rs1", 32'(bus.rs1), 32'(si[19:15]));
      check_eq("rs2", 32'(bus.rs2), 32'(si[24:20]));
      check_eq("rd", 32'(bus.rd), 32'(si[11:7]));
    end
  endtask

  // Advance the model by the transfers of the current cycle, then the clock.
  task automatic tick();
    bit          bub, out, take;
    logic [31:0] si;
    bub  = bubble_now();
    si   = shown_inst();
    out  = (slot.size() != 0) && c_rdy;
    take = c_v && m_ready;
    if (out) begin
      m_ld = (si[6:0] == 7'h03);
      m_rd = si[11:7];
      if (!bub) slot.delete(0);
    end
    if (c_fl) begin
      slot.delete();
      m_ld = 1'b0;
    end else if (take) begin
      slot.push_back('{inst: c_inst, pc: c_pc});
    end
    @(posedge clk);
  endtask

  task automatic check_reset_view(input string tag);
    check_eq({tag, "_if_ready"}, 32'(bus.if_ready), 32'd0);
    check_eq({tag, "_id_valid"}, 32'(bus.id_valid), 32'd0);
    check_eq({tag, "_id_inst"}, bus.id_inst, NOP);
    check_eq({tag, "_id_pc"}, bus.id_pc, 32'd0);
    check_eq({tag, "_imm_sel"}, 32'(bus.imm_sel), 32'd0);
  endtask

  // Assert reset between edges (called right after a rising edge).
  task automatic reset_mid();
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_view("rst_mid");
    model_reset();
    @(negedge clk);
    bus.if_valid = 1'b0; bus.flush = 1'b0; bus.id_ready = 1'b0;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    bus.if_valid = 1'b0; bus.if_inst = 32'd0; bus.if_pc = 32'd0;
    bus.flush = 1'b0; bus.id_ready = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    bus.if_valid = 1'b1;
    #1;
    check_reset_view("rst");
    bus.if_valid = 1'b0;
    rst_n = 1'b1;

    // addi x1,x0,1 at pc 0
    step(1'b1, 32'h0010_0093, 32'd0, 1'b0, 1'b1); tick();
    step(1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
    check_eq("addi_valid", 32'(bus.id_valid), 32'd1);
    check_eq("addi_imm_sel", 32'(bus.imm_sel), 32'd1);
    check_eq("addi_rd", 32'(bus.rd), 32'd1);
    check_eq("addi_imm_inst", 32'(bus.imm_inst), 32'h0002001);
    tick();

    // lw x5 then dependent add: one bubble
    step(1'b1, 32'h0000_A283, 32'd4, 1'b0, 1'b1); tick();
    step(1'b1, 32'h0022_8333, 32'd8, 1'b0, 1'b1); tick();
    step(1'b1, 32'h0010_0093, 32'd12, 1'b0, 1'b1);
    check_eq("lu_bubble_inst", bus.id_inst, 32'h0000_0013);
    check_eq("lu_bubble_sel", 32'(bus.imm_sel), 32'd0);
    check_eq("lu_bubble_ready", 32'(bus.if_ready), 32'd0);
    check_eq("lu_bubble_pc", bus.id_pc, 32'd8);
    tick();
    step(1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
    check_eq("lu_add_issue", bus.id_inst, 32'h0022_8333);
    tick();

    // lw x0 then add reading x0: no bubble
    step(1'b1, 32'h0000_A003, 32'd16, 1'b0, 1'b1); tick();
    step(1'b1, 32'h0000_0333, 32'd20, 1'b0, 1'b1);
    check_eq("x0_ready", 32'(bus.if_ready), 32'd1);
    tick();
    step(1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
    check_eq("x0_no_bubble", bus.id_inst, 32'h0000_0333);
    tick();

    // three stall cycles
    step(1'b1, 32'h0010_0093, 32'd24, 1'b0, 1'b1); tick();
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 32'h0020_0113, 32'd28, 1'b0, 1'b0);
      check_eq("stall_ready", 32'(bus.if_ready), 32'd0);
      check_eq("stall_inst", bus.id_inst, 32'h0010_0093);
      check_eq("stall_pc", bus.id_pc, 32'd24);
      tick();
    end
    step(1'b1, 32'h0020_0113, 32'd28, 1'b0, 1'b1); tick();
    step(1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
    check_eq("stall_adv_inst", bus.id_inst, 32'h0020_0113);
    check_eq("stall_adv_pc", bus.id_pc, 32'd28);
    tick();

    // flush with lw leaving, then dependent add: no bubble
    step(1'b1, 32'h0000_A283, 32'd32, 1'b0, 1'b1); tick();
    step(1'b1, 32'h0010_0093, 32'd36, 1'b1, 1'b1); tick();
    step(1'b1, 32'h0022_8333, 32'd40, 1'b0, 1'b1);
    check_eq("flush_empty", 32'(bus.id_valid), 32'd0);
    tick();
    step(1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
    check_eq("flush_no_bubble", bus.id_inst, 32'h0022_8333);
    tick();

    // reset while VALID, between edges
    step(1'b1, 32'h0010_0093, 32'd44, 1'b0, 1'b0); tick();
    step(1'b1, 32'h0020_0113, 32'd48, 1'b0, 1'b0); tick();
    reset_mid();

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      step(($urandom % 4) != 0, rand_inst(), $urandom & 32'hFFFF_FFFC,
           ($urandom % 16) == 0, ($urandom % 4) != 0);
      tick();
      if (n % 1000 == 500) reset_mid();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
